// File: rtl/simd_mem_pkg.sv
// Shared types and legal parameter ranges for the SIMD memory subsystem.
package simd_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } state_t;

  localparam int unsigned RL_MIN  = 1;
  localparam int unsigned RL_MAX  = 2;
  localparam int unsigned SRC_MIN = 1;
  localparam int unsigned SRC_MAX = 4;

endpackage

// File: rtl/sdp_ram.sv
// Inferred simple-dual-port RAM: write port A, read-first read port B with
// 1- or 2-cycle latency. b_ce freezes the whole read pipeline.
module sdp_ram #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
  parameter int unsigned LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [WIDTH-1:0]      a_data,
  input  logic                  b_re,
  input  logic                  b_ce,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  output logic [WIDTH-1:0]      b_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_q;

  // Read and write in one block so a same-address collision returns old data.
  always_ff @(posedge clk) begin
    if (a_we) mem[a_addr] <= a_data;
    if (b_re && b_ce) rd_q <= mem[b_addr];
  end

  if (LATENCY == 2) begin : g_oreg
    logic [WIDTH-1:0] out_q;
    always_ff @(posedge clk) begin
      if (b_ce) out_q <= rd_q;
    end
    assign b_data = out_q;
  end else begin : g_noreg
    assign b_data = rd_q;
  end

endmodule

// File: rtl/simd_mem_ctrl.sv
// Operand/result/instruction banks plus the run controller that streams
// instructions to the SIMD datapath and reports completion to the PS.
module simd_mem_ctrl
  import simd_mem_pkg::*;
#(
  parameter int unsigned PE_COUNT       = 8,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned BRAM_DEPTH     = 1024,
  parameter int unsigned ADDR_WIDTH     = $clog2(BRAM_DEPTH),
  parameter int unsigned INS_DEPTH      = 2048,
  parameter int unsigned INS_ADDR_WIDTH = $clog2(INS_DEPTH),
  parameter int unsigned INS_WIDTH      = 64,
  parameter int unsigned NUM_SRC        = 2,
  parameter int unsigned READ_LATENCY   = 1
) (
  input  logic                                   clk,
  input  logic                                   rstn,
  input  logic                                   start,
  input  logic [INS_ADDR_WIDTH:0]                ins_count,
  input  logic                                   stall,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   host_wr_err,
  input  logic [NUM_SRC-1:0]                     host_op_wr_en,
  input  logic [ADDR_WIDTH-1:0]                  host_op_wr_addr,
  input  logic [PE_COUNT*DATA_WIDTH-1:0]         host_op_wr_data,
  input  logic                                   host_ins_wr_en,
  input  logic [INS_ADDR_WIDTH-1:0]              host_ins_wr_addr,
  input  logic [INS_WIDTH-1:0]                   host_ins_wr_data,
  input  logic                                   host_r_rd_req,
  input  logic [ADDR_WIDTH-1:0]                  host_r_rd_addr,
  output logic                                   host_r_rd_valid,
  output logic [PE_COUNT*DATA_WIDTH-1:0]         host_r_rd_data,
  output logic [INS_WIDTH-1:0]                   dp_ins,
  output logic                                   dp_ins_valid,
  input  logic [NUM_SRC*ADDR_WIDTH-1:0]          dp_op_rd_addr,
  output logic [NUM_SRC*PE_COUNT*DATA_WIDTH-1:0] dp_op_rd_data,
  input  logic                                   dp_r_wr_en,
  input  logic [ADDR_WIDTH-1:0]                  dp_r_wr_addr,
  input  logic [PE_COUNT*DATA_WIDTH-1:0]         dp_r_wr_data,
  input  logic                                   dp_idle
);

  localparam int unsigned LW = PE_COUNT * DATA_WIDTH;
  localparam int unsigned CW = INS_ADDR_WIDTH + 1;
  localparam logic [CW-1:0] INS_MAX = CW'(INS_DEPTH);

  if (READ_LATENCY < RL_MIN || READ_LATENCY > RL_MAX) begin : g_bad_rl
    $error("simd_mem_ctrl: READ_LATENCY must be 1 or 2");
  end
  if (NUM_SRC < SRC_MIN || NUM_SRC > SRC_MAX) begin : g_bad_src
    $error("simd_mem_ctrl: NUM_SRC must be 1..4");
  end

  state_t                  state;
  logic [CW-1:0]           pc;
  logic [CW-1:0]           cnt;
  logic                    busy_q;
  logic                    done_q;
  logic                    err_q;
  logic [READ_LATENCY-1:0] ins_vld;
  logic [READ_LATENCY-1:0] rd_vld;
  logic                    issue;
  logic                    host_wr_try;
  logic [NUM_SRC-1:0]      op_we;
  logic                    ins_we;
  logic                    res_we;

  assign issue       = (state == FETCH) && !stall;
  assign host_wr_try = (|host_op_wr_en) || host_ins_wr_en;
  assign op_we       = host_op_wr_en & {NUM_SRC{~busy_q}};
  assign ins_we      = host_ins_wr_en & ~busy_q;
  assign res_we      = dp_r_wr_en & busy_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      pc     <= '0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (host_wr_try && busy_q) err_q <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            err_q <= 1'b0;
            pc    <= '0;
            if (ins_count == '0) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state  <= FETCH;
              busy_q <= 1'b1;
              cnt    <= (ins_count > INS_MAX) ? INS_MAX : ins_count;
            end
          end
        end
        FETCH: begin
          if (!stall) begin
            pc <= pc + 1'b1;
            if (pc == cnt - 1'b1) state <= DRAIN;
          end
        end
        DRAIN: begin
          if ((ins_vld == '0) && dp_idle) begin
            state  <= DONE;
            done_q <= 1'b1;
            busy_q <= 1'b0;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // The instruction valid pipe and the RAM output stages share the ~stall
  // enable, so a stalled instruction is re-presented rather than lost.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ins_vld <= '0;
      rd_vld  <= '0;
    end else begin
      if (!stall) ins_vld <= READ_LATENCY'({ins_vld, issue});
      rd_vld <= READ_LATENCY'({rd_vld, host_r_rd_req});
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign host_wr_err     = err_q;
  assign dp_ins_valid    = ins_vld[READ_LATENCY-1] & ~stall;
  assign host_r_rd_valid = rd_vld[READ_LATENCY-1];

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_op
    sdp_ram #(
      .WIDTH     (LW),
      .DEPTH     (BRAM_DEPTH),
      .ADDR_WIDTH(ADDR_WIDTH),
      .LATENCY   (READ_LATENCY)
    ) u_op_ram (
      .clk   (clk),
      .a_we  (op_we[i]),
      .a_addr(host_op_wr_addr),
      .a_data(host_op_wr_data),
      .b_re  (1'b1),
      .b_ce  (1'b1),
      .b_addr(dp_op_rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]),
      .b_data(dp_op_rd_data[i*LW +: LW])
    );
  end

  sdp_ram #(
    .WIDTH     (LW),
    .DEPTH     (BRAM_DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .LATENCY   (READ_LATENCY)
  ) u_res_ram (
    .clk   (clk),
    .a_we  (res_we),
    .a_addr(dp_r_wr_addr),
    .a_data(dp_r_wr_data),
    .b_re  (1'b1),
    .b_ce  (1'b1),
    .b_addr(host_r_rd_addr),
    .b_data(host_r_rd_data)
  );

  sdp_ram #(
    .WIDTH     (INS_WIDTH),
    .DEPTH     (INS_DEPTH),
    .ADDR_WIDTH(INS_ADDR_WIDTH),
    .LATENCY   (READ_LATENCY)
  ) u_ins_ram (
    .clk   (clk),
    .a_we  (ins_we),
    .a_addr(host_ins_wr_addr),
    .a_data(host_ins_wr_data),
    .b_re  (issue),
    .b_ce  (~stall),
    .b_addr(pc[INS_ADDR_WIDTH-1:0]),
    .b_data(dp_ins)
  );

endmodule

// File: tb/tb_simd_mem_ctrl.sv
// Directed bench: operand broadcast table, fetch runs with stall/drain/error,
// result read-first at latency 2, count clamp, zero count and mid-run reset.
module tb_simd_mem_ctrl;

  localparam int unsigned LW = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Instance 1: NUM_SRC=3, READ_LATENCY=1, default depths
  logic          start1, stall1, busy1, done1, err1, idle1;
  logic [11:0]   ins_count1;
  logic [2:0]    op_we1;
  logic [9:0]    op_waddr1;
  logic [LW-1:0] op_wdata1;
  logic          ins_we1;
  logic [10:0]   ins_waddr1;
  logic [63:0]   ins_wdata1;
  logic          rreq1, rvalid1, dp_vld1, rwe1;
  logic [9:0]    raddr1, rwaddr1;
  logic [LW-1:0] rdata1, rwdata1;
  logic [63:0]   dp_ins1;
  logic [29:0]   op_raddr1;
  logic [767:0]  op_rdata1;

  // Instance 2: NUM_SRC=2, READ_LATENCY=2, INS_DEPTH=16, BRAM_DEPTH=64
  logic          start2, stall2, busy2, done2, err2, idle2;
  logic [4:0]    ins_count2;
  logic [1:0]    op_we2;
  logic [5:0]    op_waddr2;
  logic [LW-1:0] op_wdata2;
  logic          ins_we2;
  logic [3:0]    ins_waddr2;
  logic [63:0]   ins_wdata2;
  logic          rreq2, rvalid2, dp_vld2, rwe2;
  logic [5:0]    raddr2, rwaddr2;
  logic [LW-1:0] rdata2, rwdata2;
  logic [63:0]   dp_ins2;
  logic [11:0]   op_raddr2;
  logic [511:0]  op_rdata2;

  simd_mem_ctrl #(.NUM_SRC(3), .READ_LATENCY(1)) u_dut1 (
    .clk(clk), .rstn(rstn), .start(start1), .ins_count(ins_count1), .stall(stall1),
    .busy(busy1), .done(done1), .host_wr_err(err1),
    .host_op_wr_en(op_we1), .host_op_wr_addr(op_waddr1), .host_op_wr_data(op_wdata1),
    .host_ins_wr_en(ins_we1), .host_ins_wr_addr(ins_waddr1), .host_ins_wr_data(ins_wdata1),
    .host_r_rd_req(rreq1), .host_r_rd_addr(raddr1), .host_r_rd_valid(rvalid1),
    .host_r_rd_data(rdata1), .dp_ins(dp_ins1), .dp_ins_valid(dp_vld1),
    .dp_op_rd_addr(op_raddr1), .dp_op_rd_data(op_rdata1),
    .dp_r_wr_en(rwe1), .dp_r_wr_addr(rwaddr1), .dp_r_wr_data(rwdata1), .dp_idle(idle1)
  );

  simd_mem_ctrl #(.NUM_SRC(2), .READ_LATENCY(2), .INS_DEPTH(16), .BRAM_DEPTH(64)) u_dut2 (
    .clk(clk), .rstn(rstn), .start(start2), .ins_count(ins_count2), .stall(stall2),
    .busy(busy2), .done(done2), .host_wr_err(err2),
    .host_op_wr_en(op_we2), .host_op_wr_addr(op_waddr2), .host_op_wr_data(op_wdata2),
    .host_ins_wr_en(ins_we2), .host_ins_wr_addr(ins_waddr2), .host_ins_wr_data(ins_wdata2),
    .host_r_rd_req(rreq2), .host_r_rd_addr(raddr2), .host_r_rd_valid(rvalid2),
    .host_r_rd_data(rdata2), .dp_ins(dp_ins2), .dp_ins_valid(dp_vld2),
    .dp_op_rd_addr(op_raddr2), .dp_op_rd_data(op_rdata2),
    .dp_r_wr_en(rwe2), .dp_r_wr_addr(rwaddr2), .dp_r_wr_data(rwdata2), .dp_idle(idle2)
  );

  typedef struct {
    logic [2:0]      en;
    logic [9:0]      addr;
    logic [7:0]      pat;
    logic [2:0][7:0] exp;   // {bank2, bank1, bank0}
  } op_vec_t;

  op_vec_t ops [7];

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One run on instance 1; stall window, dropped-write cycle and dp_idle rise
  // are given as window indices counted from the start edge (0 = unused).
  task automatic run1(input int unsigned count, input int unsigned s_at, input int unsigned s_len,
                      input int unsigned wr_at, input int unsigned idle_at,
                      input logic [63:0] base, output int unsigned done_c);
    int unsigned k, first, last, ndone;
    logic busy_prev;
    bit fin;
    k = 0; first = 0; last = 0; ndone = 0; fin = 0; done_c = 0;
    busy_prev = busy1;
    ins_count1 = 12'(count);
    start1 = 1'b1;
    for (int unsigned c = 1; c <= 200 && !fin; c++) begin
      tick();
      start1     = 1'b0;
      stall1     = (c >= s_at) && (c < s_at + s_len);
      idle1      = (c >= idle_at);
      ins_we1    = (c == wr_at);
      ins_waddr1 = 11'd2;
      ins_wdata1 = 64'hDEAD;
      #1;
      if (c == 1) begin
        chk("busy_after_start", busy1, 1'b1);
        chk("err_clear_on_start", err1, 1'b0);
      end
      if (dp_vld1) begin
        if (k == 0) first = c;
        chk("ins_seq", dp_ins1, base + 64'(k));
        k++;
        last = c;
      end
      if (done1) begin
        ndone++;
        if (ndone == 1) begin
          done_c = c;
          chk("busy_falls_with_done", {busy_prev, busy1}, 2'b10);
        end
      end
      if (ndone > 0 && c >= done_c + 3) fin = 1;
      busy_prev = busy1;
    end
    stall1 = 1'b0; idle1 = 1'b1; ins_we1 = 1'b0;
    chk("valid_count", k, count);
    chk("first_valid_cycle", first, 2);
    chk("done_pulses", ndone, 1);
    chk("done_after_last_valid", done_c > last, 1'b1);
    if (idle_at > 1) chk("drain_waits_idle", done_c > idle_at, 1'b1);
  endtask

  initial begin
    int unsigned d0, d1, d2, d3, k, first, ndone;
    logic [LW-1:0] old_v, new_v, b_v, c_v;

    ops[0] = '{3'b111, 10'd7,    8'h11, {8'h11, 8'h11, 8'h11}};
    ops[1] = '{3'b101, 10'd7,    8'hA5, {8'hA5, 8'h11, 8'hA5}};
    ops[2] = '{3'b111, 10'd0,    8'h5A, {8'h5A, 8'h5A, 8'h5A}};
    ops[3] = '{3'b100, 10'd0,    8'hC3, {8'hC3, 8'h5A, 8'h5A}};
    ops[4] = '{3'b111, 10'd1023, 8'h77, {8'h77, 8'h77, 8'h77}};
    ops[5] = '{3'b010, 10'd1023, 8'hE1, {8'h77, 8'hE1, 8'h77}};
    ops[6] = '{3'b000, 10'd7,    8'hFF, {8'hA5, 8'h11, 8'hA5}};

    rstn = 1'b0;
    start1 = 0; stall1 = 0; idle1 = 1; ins_count1 = '0; op_we1 = '0; op_waddr1 = '0;
    op_wdata1 = '0; ins_we1 = 0; ins_waddr1 = '0; ins_wdata1 = '0; rreq1 = 0; raddr1 = '0;
    rwe1 = 0; rwaddr1 = '0; rwdata1 = '0; op_raddr1 = '0;
    start2 = 0; stall2 = 0; idle2 = 1; ins_count2 = '0; op_we2 = '0; op_waddr2 = '0;
    op_wdata2 = '0; ins_we2 = 0; ins_waddr2 = '0; ins_wdata2 = '0; rreq2 = 0; raddr2 = '0;
    rwe2 = 0; rwaddr2 = '0; rwdata2 = '0; op_raddr2 = '0;
    tick(); tick();
    chk("rst_busy", busy1, 1'b0);
    chk("rst_done", done1, 1'b0);
    chk("rst_err", err1, 1'b0);
    chk("rst_ins_valid", dp_vld1, 1'b0);
    chk("rst_rd_valid", rvalid2, 1'b0);
    rstn = 1'b1;
    tick();

    // Operand bank write/broadcast table
    for (int unsigned v = 0; v < 7; v++) begin
      op_we1 = ops[v].en; op_waddr1 = ops[v].addr; op_wdata1 = {32{ops[v].pat}};
      tick();
      op_we1 = '0;
      op_raddr1 = {3{ops[v].addr}};
      tick();
      for (int unsigned b = 0; b < 3; b++)
        chk("op_bank_read", op_rdata1[b*LW +: LW], {32{ops[v].exp[b]}});
    end

    for (int unsigned i = 0; i < 10; i++) begin
      ins_we1 = 1'b1; ins_waddr1 = 11'(i); ins_wdata1 = 64'(100 + i);
      tick();
    end
    ins_we1 = 1'b0;
    tick();

    run1(10, 0, 0, 0, 0, 64'd100, d0);
    tick();
    run1(10, 5, 3, 0, 0, 64'd100, d1);
    chk("stall_done_delay", d1 - d0, 3);
    tick();
    run1(10, 0, 0, 3, 0, 64'd100, d2);
    tick(); tick();
    chk("err_sticky", err1, 1'b1);
    run1(10, 0, 0, 0, 25, 64'd100, d3);

    // Zero-length run
    tick();
    ins_count1 = '0; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("zero_done", done1, 1'b1);
    chk("zero_busy", busy1, 1'b0);
    chk("zero_valid", dp_vld1, 1'b0);
    tick();
    chk("zero_done_single", done1, 1'b0);
    chk("zero_valid_after", dp_vld1, 1'b0);

    // Instance 2: clamp, RL=2 fetch, result read-first
    for (int unsigned i = 0; i < 16; i++) begin
      ins_we2 = 1'b1; ins_waddr2 = 4'(i); ins_wdata2 = 64'(200 + i);
      tick();
    end
    ins_we2 = 1'b0;
    ins_count2 = 5'd20; idle2 = 1'b0; start2 = 1'b1;
    k = 0; first = 0;
    for (int unsigned c = 1; c <= 30; c++) begin
      tick();
      start2 = 1'b0;
      if (dp_vld2) begin
        if (k == 0) first = c;
        chk("clamp_seq", dp_ins2, 64'(200 + k));
        k++;
      end
    end
    chk("clamp_count", k, 16);
    chk("rl2_first_valid", first, 3);
    chk("drain_holds_busy", busy2, 1'b1);

    old_v = {32{8'h3C}}; new_v = {32{8'h96}}; b_v = {32{8'h4B}}; c_v = {32{8'hD2}};
    rwe2 = 1'b1; rwaddr2 = 6'd5; rwdata2 = old_v;
    tick();
    rwaddr2 = 6'd6; rwdata2 = b_v;
    tick();
    rwaddr2 = 6'd5; rwdata2 = new_v; rreq2 = 1'b1; raddr2 = 6'd5;
    tick();
    rwe2 = 1'b0;
    chk("rd_not_early", rvalid2, 1'b0);
    tick();
    rreq2 = 1'b0;
    chk("rd_valid_lat2", rvalid2, 1'b1);
    chk("rd_first_old", rdata2, old_v);
    tick();
    chk("rd_pipelined_valid", rvalid2, 1'b1);
    chk("rd_second_new", rdata2, new_v);
    tick();
    chk("rd_valid_drop", rvalid2, 1'b0);

    idle2 = 1'b1; ndone = 0;
    for (int unsigned c = 0; c < 20; c++) begin
      tick();
      if (done2) ndone++;
    end
    chk("rl2_done_pulses", ndone, 1);
    chk("rl2_idle_busy", busy2, 1'b0);
    rwe2 = 1'b1; rwaddr2 = 6'd6; rwdata2 = c_v;
    tick();
    rwe2 = 1'b0; rreq2 = 1'b1; raddr2 = 6'd6;
    tick();
    rreq2 = 1'b0;
    tick();
    chk("idle_res_write_dropped", rdata2, b_v);

    // Reset during FETCH
    ins_count1 = 12'd10; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick(); tick();
    chk("pre_reset_busy", busy1, 1'b1);
    rstn = 1'b0;
    #1;
    chk("reset_busy", busy1, 1'b0);
    chk("reset_valid", dp_vld1, 1'b0);
    chk("reset_done", done1, 1'b0);
    tick(); tick();
    rstn = 1'b1;
    ndone = 0;
    for (int unsigned c = 0; c < 15; c++) begin
      tick();
      if (done1 || busy1 || dp_vld1) ndone++;
    end
    chk("reset_no_done", ndone, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/simd_mem_ctrl.md
Name: simd_mem_ctrl

Overview:
- Parametrised memory subsystem and run controller for the SIMD datapath.
- Owns NUM_SRC operand banks, one result bank and one instruction bank as inferred simple-dual-port RAMs with configurable read latency.
- Sequences the program counter from start to completion: fetch pipeline with stall, drain, done pulse.
- Gives the PS write, readback and error reporting, and replaces fixed two-operand vendor-IP wiring.

Parameters:
PE_COUNT, 8, lanes per memory word
DATA_WIDTH, 32, bits per lane
BRAM_DEPTH, 1024, words per operand/result bank
ADDR_WIDTH, $clog2(BRAM_DEPTH), operand/result address width
INS_DEPTH, 2048, instruction words
INS_ADDR_WIDTH, $clog2(INS_DEPTH), instruction address width
INS_WIDTH, 64, instruction word width
NUM_SRC, 2, operand bank count (1..4)
READ_LATENCY, 1, RAM read latency in cycles (1 or 2; 2 adds output register)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
start  in  1  run request pulse
ins_count  in  INS_ADDR_WIDTH+1  instructions to issue
stall  in  1  freeze fetch pipeline
busy  out  1  run in progress
done  out  1  one-cycle completion pulse
host_wr_err  out  1  sticky: host write dropped during run
host_op_wr_en  in  NUM_SRC  per-bank write enable; several bits set broadcasts the data
host_op_wr_addr  in  ADDR_WIDTH  operand write address
host_op_wr_data  in  PE_COUNT*DATA_WIDTH  operand write data
host_ins_wr_en  in  1  instruction write enable
host_ins_wr_addr  in  INS_ADDR_WIDTH  instruction write address
host_ins_wr_data  in  INS_WIDTH  instruction write data
host_r_rd_req  in  1  result read request
host_r_rd_addr  in  ADDR_WIDTH  result read address
host_r_rd_valid  out  1  result data valid
host_r_rd_data  out  PE_COUNT*DATA_WIDTH  result read data
dp_ins  out  INS_WIDTH  fetched instruction
dp_ins_valid  out  1  dp_ins valid
dp_op_rd_addr  in  NUM_SRC*ADDR_WIDTH  operand read addresses, bank i at slice i
dp_op_rd_data  out  NUM_SRC*PE_COUNT*DATA_WIDTH  operand read data, READ_LATENCY after address
dp_r_wr_en  in  1  result write enable
dp_r_wr_addr  in  ADDR_WIDTH  result write address
dp_r_wr_data  in  PE_COUNT*DATA_WIDTH  result write data
dp_idle  in  1  datapath pipeline empty

Behaviour:
- Reset values: busy=0, done=0, host_wr_err=0, dp_ins_valid=0, host_r_rd_valid=0, pc=0, FSM=IDLE. RAM contents are not reset; data outputs are don't-care until their valid is set.
- FSM states: IDLE, FETCH, DRAIN, DONE.
- IDLE: start=1 and ins_count>0 -> FETCH, pc=0, host_wr_err cleared, busy=1 next cycle. start=1 and ins_count=0 -> DONE directly.
- FETCH: each cycle with stall=0, issue the read at pc and increment pc. After ins_count issues -> DRAIN.
- FETCH, stall=1: pc holds, the instruction RAM read enable is low (output holds), and the valid shift register (depth READ_LATENCY) freezes.
- dp_ins_valid: asserted READ_LATENCY unstalled cycles after issue, high for exactly ins_count unstalled cycles per run.
- DRAIN: wait until the valid pipe is empty and dp_idle=1 -> DONE.
- DONE: done=1 for one cycle, busy drops the same cycle -> IDLE.
- start while busy is ignored. pc never wraps: ins_count > INS_DEPTH is clamped to INS_DEPTH.
- Host operand/instruction writes while busy are dropped and set host_wr_err. Writes in IDLE take effect the cycle after.
- dp_r_wr_en is honoured only while busy; otherwise it is dropped silently.
- Result reads are allowed at any time: host_r_rd_valid follows host_r_rd_req by READ_LATENCY cycles, fully pipelined.
- Result read and write to the same address in the same cycle return old data (read-first).
- Operand reads are unconditional and ignore stall; the datapath re-presents addresses as needed.
- Reset asserted mid-run aborts immediately to IDLE with no done pulse.

Decomposition:
- Package simd_mem_pkg: state enum (IDLE/FETCH/DRAIN/DONE) and READ_LATENCY legal-range constants.
- Sub-module sdp_ram: parametrised width/depth/latency, write port A, read port B with enable, read-first, inferred. Instantiated NUM_SRC+2 times via generate.

Test Plan:
- Load instruction words 0..9 = 100+i, start with ins_count=10, READ_LATENCY=1 -> dp_ins_valid high 10 cycles carrying 100..109 starting 1 cycle after FETCH entry; with dp_idle=1, done pulses once and busy falls the same cycle.
- Same run with stall high for 3 cycles at pc=4 -> no duplicated or lost instruction; sequence still 100..109, valid cycles total 10, done delayed by 3.
- NUM_SRC=3, host_op_wr_en=3'b101 writing 0xA5 lanes to addr 7 -> banks 0 and 2 return the pattern at addr 7, bank 1 unchanged.
- Host instruction write during FETCH -> instruction RAM unchanged, host_wr_err=1 until the next start.
- dp_r_wr to addr 5 value X while host reads addr 5 in the same cycle, READ_LATENCY=2 -> valid after 2 cycles with old data; a second read returns X.
- ins_count=0 -> done the cycle after start, dp_ins_valid never set. rstn low mid-FETCH -> busy=0, no done pulse.
